// File: rtl/cc_rdata_arbiter_if.sv
// Read-data arbiter bus: two FIFO read ports plus the shared beat channel.
// The slave view belongs to the arbiter, the master view to its surroundings.
interface cc_rdata_arbiter_if;
    logic         hit_empty_i;
    logic [517:0] hit_rdata_i;
    logic         hit_rden_o;
    logic         miss_empty_i;
    logic [517:0] miss_rdata_i;
    logic         miss_rden_o;
    logic [63:0]  rdata_o;
    logic         rlast_o;
    logic         rvalid_o;
    logic         rready_i;
    logic         rsrc_o;
    logic         busy_o;

    modport slave (
        input  hit_empty_i, hit_rdata_i,
        input  miss_empty_i, miss_rdata_i,
        input  rready_i,
        output hit_rden_o, miss_rden_o,
        output rdata_o, rlast_o, rvalid_o,
        output rsrc_o, busy_o
    );

    modport master (
        output hit_empty_i, hit_rdata_i,
        output miss_empty_i, miss_rdata_i,
        output rready_i,
        input  hit_rden_o, miss_rden_o,
        input  rdata_o, rlast_o, rvalid_o,
        input  rsrc_o, busy_o
    );
endinterface

// File: rtl/cc_rdata_arbiter.sv
// Round-robin arbiter streaming 512-bit FIFO heads as 8-beat
// critical-word-first bursts over one 64-bit read channel.
module cc_rdata_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    cc_rdata_arbiter_if.slave bus
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t       state_q, state_d;
    logic         gnt_q, gnt_d;
    logic [2:0]   off_q, off_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         last_q, last_d;

    logic [517:0] head;
    logic [511:0] line;
    logic [2:0]   idx;
    logic [8:0]   base;
    logic         hit_req, miss_req;

    // Select the granted head and the current beat's word position.
    always_comb begin
        head     = gnt_q ? bus.miss_rdata_i : bus.hit_rdata_i;
        line     = head[511:0];
        idx      = off_q + cnt_q;
        base     = 9'd511 - {idx, 6'd0};
        hit_req  = !bus.hit_empty_i;
        miss_req = !bus.miss_empty_i;
    end

    // Arbitration, beat sequencing and channel outputs.
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        off_d           = off_q;
        cnt_d           = cnt_q;
        last_d          = last_q;
        bus.rvalid_o    = 1'b0;
        bus.rlast_o     = 1'b0;
        bus.rdata_o     = '0;
        bus.rsrc_o      = 1'b0;
        bus.busy_o      = 1'b0;
        bus.hit_rden_o  = 1'b0;
        bus.miss_rden_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit_req || miss_req) begin
                    state_d = BURST;
                    gnt_d   = (hit_req && miss_req) ? ~last_q : miss_req;
                    off_d   = gnt_d ? bus.miss_rdata_i[517:515]
                                    : bus.hit_rdata_i[517:515];
                    cnt_d   = 3'd0;
                end
            end
            BURST: begin
                bus.rvalid_o = 1'b1;
                bus.busy_o   = 1'b1;
                bus.rsrc_o   = gnt_q;
                bus.rdata_o  = line[base -: 64];
                bus.rlast_o  = (cnt_q == 3'd7);
                if (bus.rready_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d         = IDLE;
                        last_d          = gnt_q;
                        bus.hit_rden_o  = ~gnt_q;
                        bus.miss_rden_o = gnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset leaves RR_INIT as the tie winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            off_q   <= 3'd0;
            cnt_q   <= 3'd0;
            last_q  <= ~RR_INIT;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_cc_rdata_arbiter.sv
// Directed bench for cc_rdata_arbiter with small FIFO models on
// both read ports and per-beat expected data built from tags.
module tb_cc_rdata_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    cc_rdata_arbiter_if bus();

    cc_rdata_arbiter #(.RR_INIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [517:0] hmem [8];
    logic [517:0] mmem [8];
    logic [2:0]   hwr = 3'd0;
    logic [2:0]   hrd = 3'd0;
    logic [2:0]   mwr = 3'd0;
    logic [2:0]   mrd = 3'd0;

    assign bus.hit_empty_i  = (hwr == hrd);
    assign bus.hit_rdata_i  = hmem[hrd];
    assign bus.miss_empty_i = (mwr == mrd);
    assign bus.miss_rdata_i = mmem[mrd];

    always @(posedge clk) begin
        if (bus.hit_rden_o)  hrd <= hrd + 3'd1;
        if (bus.miss_rden_o) mrd <= mrd + 3'd1;
    end

    function automatic logic [517:0] mk(input logic [2:0] off,
                                        input logic [7:0] tag);
        logic [517:0] e;
        e = '0;
        e[517:515] = off;
        e[514:512] = 3'b101;
        for (int k = 0; k < 8; k++)
            e[511 - 64 * k -: 64] = {tag, 53'd0, 3'(k)};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_hit(input logic [2:0] off, input logic [7:0] tag);
        hmem[hwr] = mk(off, tag);
        hwr = hwr + 3'd1;
    endtask

    task automatic push_miss(input logic [2:0] off, input logic [7:0] tag);
        mmem[mwr] = mk(off, tag);
        mwr = mwr + 3'd1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'd0);
        chk({tag, "_rlast"}, 64'(bus.rlast_o), 64'd0);
        chk({tag, "_rdata"}, bus.rdata_o, 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, "_rden"}, 64'({bus.hit_rden_o, bus.miss_rden_o}), 64'd0);
    endtask

    // Expects rvalid at the next falling edge; stall applies 1,0,0 ready.
    // disturb pushes then rewrites a hit entry mid-burst.
    task automatic run_burst(input string tag, input bit src,
                             input logic [2:0] off, input logic [7:0] dt,
                             input bit stall, input bit disturb);
        int beat = 0;
        int cyc = 0;
        bit rdy;
        logic [2:0] w;
        while (beat < 8 && cyc < 64) begin
            @(negedge clk);
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            bus.rready_i = rdy;
            #1;
            w = off + 3'(beat);
            chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'd1);
            chk({tag, "_rsrc"}, 64'(bus.rsrc_o), 64'(src));
            chk({tag, "_rdata"}, bus.rdata_o, {dt, 53'd0, w});
            chk({tag, "_rlast"}, 64'(bus.rlast_o), 64'(beat == 7));
            chk({tag, "_hit_rden"}, 64'(bus.hit_rden_o),
                64'(rdy && beat == 7 && !src));
            chk({tag, "_miss_rden"}, 64'(bus.miss_rden_o),
                64'(rdy && beat == 7 && src));
            if (disturb && cyc == 2) push_hit(3'd1, 8'h71);
            if (disturb && cyc == 5) hmem[hrd] = mk(3'd4, 8'h72);
            if (rdy) beat++;
            cyc++;
        end
        checks++;
        if (beat != 8) begin
            failures++;
            $error("FAIL %s_timeout observed=%0d expected=8", tag, beat);
        end
        @(negedge clk);
        #1;
        chk({tag, "_bubble_rvalid"}, 64'(bus.rvalid_o), 64'd0);
        chk({tag, "_bubble_busy"}, 64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        bus.rready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hmem[i] = '0;
            mmem[i] = '0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        chk("reset_rsrc", 64'(bus.rsrc_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("idle_empty");

        // Hit only, offset 0.
        push_hit(3'd0, 8'h11);
        #1;
        chk("hit0_pre_rvalid", 64'(bus.rvalid_o), 64'd0);
        run_burst("hit0", 1'b0, 3'd0, 8'h11, 1'b0, 1'b0);
        chk("hit0_popped", 64'(hrd), 64'd1);

        // Miss only, offset 5.
        push_miss(3'd5, 8'h22);
        run_burst("miss5", 1'b1, 3'd5, 8'h22, 1'b0, 1'b0);
        chk("miss5_popped", 64'(mrd), 64'd1);

        // Round robin from reset with both FIFOs loaded.
        rst = 1'b1;
        push_hit(3'd2, 8'h31);
        push_hit(3'd7, 8'h33);
        push_miss(3'd1, 8'h32);
        push_miss(3'd3, 8'h34);
        #1;
        chk_idle("rr_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rr_grant_rvalid", 64'(bus.rvalid_o), 64'd0);
        run_burst("rr_h1", 1'b0, 3'd2, 8'h31, 1'b0, 1'b0);
        run_burst("rr_m1", 1'b1, 3'd1, 8'h32, 1'b0, 1'b0);
        run_burst("rr_h2", 1'b0, 3'd7, 8'h33, 1'b0, 1'b0);
        run_burst("rr_m2", 1'b1, 3'd3, 8'h34, 1'b0, 1'b0);
        chk("rr_all_popped", 64'({hrd, mrd}), 64'({3'd3, 3'd3}));

        // Ready stalls.
        push_hit(3'd3, 8'h41);
        run_burst("stall", 1'b0, 3'd3, 8'h41, 1'b1, 1'b0);
        chk("stall_popped", 64'(hrd), 64'd4);

        // Reset after three beats of a miss burst.
        push_miss(3'd6, 8'h51);
        bus.rready_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            #1;
            chk("abort_rdata", bus.rdata_o,
                {8'h51, 53'd0, 3'(3'd6 + 3'(b))});
        end
        #2;
        rst = 1'b1;
        #1;
        chk_idle("abort_async");
        @(posedge clk);
        @(negedge clk);
        chk("abort_not_popped", 64'(mrd), 64'd3);
        rst = 1'b0;
        #1;
        chk("abort_release_rvalid", 64'(bus.rvalid_o), 64'd0);
        run_burst("replay", 1'b1, 3'd6, 8'h51, 1'b0, 1'b0);
        chk("replay_popped", 64'(mrd), 64'd4);

        // Hit head churn during a miss burst.
        push_miss(3'd0, 8'h61);
        run_burst("isolate", 1'b1, 3'd0, 8'h61, 1'b0, 1'b1);
        chk("isolate_hit_kept", 64'(hrd), 64'd4);
        run_burst("after", 1'b0, 3'd4, 8'h72, 1'b0, 1'b0);
        chk("after_popped", 64'({hrd, mrd}), 64'({3'd5, 3'd5}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
